// File: rtl/programmable_clock_divider_pkg.sv
// Shared clocking constants for the clock-generation blocks.
package programmable_clock_divider_pkg;

   // Smallest ratio that still yields both a high and a low phase.
   localparam int unsigned MINIMUM_DIVIDER = 2;

endpackage : programmable_clock_divider_pkg

// File: rtl/programmable_clock_divider.sv
// Glitch-free divide-by-N clock generator; N changes through a valid/ready
// handshake and only takes effect at an output period boundary.
module programmable_clock_divider
   import programmable_clock_divider_pkg::*;
#(
   parameter int unsigned DIVIDER_WIDTH = 8,
   parameter int unsigned RESET_DIVIDER = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DIVIDER_WIDTH-1:0] divider,
   input  logic                     divider_valid,
   output logic                     divider_ready,
   output logic                     divider_error,
   output logic [DIVIDER_WIDTH-1:0] active_divider,
   output logic                     period_start,
   output logic                     clock_out
);

   if (RESET_DIVIDER < MINIMUM_DIVIDER ||
       64'(RESET_DIVIDER) >= (64'(1) << DIVIDER_WIDTH)) begin : g_bad_reset_divider
      $error("RESET_DIVIDER must be >= 2 and fit in DIVIDER_WIDTH bits");
   end

   localparam logic [DIVIDER_WIDTH-1:0] RESET_RATIO = DIVIDER_WIDTH'(RESET_DIVIDER);
   localparam logic [DIVIDER_WIDTH-1:0] MIN_RATIO   = DIVIDER_WIDTH'(MINIMUM_DIVIDER);

   logic                     r_run;
   logic [DIVIDER_WIDTH-1:0] r_phase;
   logic [DIVIDER_WIDTH-1:0] r_active;
   logic [DIVIDER_WIDTH-1:0] r_pending;
   logic                     r_ready;
   logic                     r_error;
   logic                     r_period_start;
   logic                     r_clock_out;

   logic                     w_wrap;
   logic                     w_start;
   logic                     w_handshake;
   logic                     w_too_small;
   logic [DIVIDER_WIDTH-1:0] w_clamped;
   logic [DIVIDER_WIDTH-1:0] w_next_active;
   logic [DIVIDER_WIDTH-1:0] w_next_phase;
   logic                     w_next_high;

   // r_run is low only on the first edge after reset, which opens the first period.
   assign w_wrap        = (r_phase == (r_active - DIVIDER_WIDTH'(1)));
   assign w_start       = !r_run || w_wrap;
   assign w_handshake   = divider_valid && r_ready;
   assign w_too_small   = (divider < MIN_RATIO);
   assign w_clamped     = w_too_small ? MIN_RATIO : divider;
   assign w_next_active = (w_start && !r_ready) ? r_pending : r_active;
   assign w_next_phase  = w_start ? '0 : (r_phase + DIVIDER_WIDTH'(1));
   assign w_next_high   = (w_next_phase < (w_next_active >> 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_run          <= 1'b0;
         r_phase        <= '0;
         r_active       <= RESET_RATIO;
         r_pending      <= '0;
         r_ready        <= 1'b1;
         r_error        <= 1'b0;
         r_period_start <= 1'b0;
         r_clock_out    <= 1'b0;
      end else begin
         r_run          <= 1'b1;
         r_phase        <= w_next_phase;
         r_active       <= w_next_active;
         r_period_start <= w_start;
         r_clock_out    <= w_next_high;
         r_error        <= w_handshake && w_too_small;
         // Accept and load are exclusive: accept needs ready high, load needs it low.
         if (w_handshake) begin
            r_pending <= w_clamped;
            r_ready   <= 1'b0;
         end else if (w_start && !r_ready) begin
            r_ready   <= 1'b1;
         end
      end
   end

   assign divider_ready  = r_ready;
   assign divider_error  = r_error;
   assign active_divider = r_active;
   assign period_start   = r_period_start;
   assign clock_out      = r_clock_out;

endmodule : programmable_clock_divider

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench: period-level reference model, run-length monitor and
// directed scenarios for the programmable clock divider.
module tb_programmable_clock_divider;

   localparam int unsigned W         = 8;
   localparam int unsigned RESET_DIV = 2;

   logic         clk;
   logic         reset;
   logic [W-1:0] divider;
   logic         divider_valid;
   logic         divider_ready;
   logic         divider_error;
   logic [W-1:0] active_divider;
   logic         period_start;
   logic         clock_out;

   programmable_clock_divider #(
      .DIVIDER_WIDTH (W),
      .RESET_DIVIDER (RESET_DIV)
   ) dut (
      .clock          (clk),
      .reset          (reset),
      .divider        (divider),
      .divider_valid  (divider_valid),
      .divider_ready  (divider_ready),
      .divider_error  (divider_error),
      .active_divider (active_divider),
      .period_start   (period_start),
      .clock_out      (clock_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: where we are inside the current output period, the
   // period length, and at most one outstanding request.
   bit chk_en = 0;
   bit rst_edge;
   bit m_started, m_pend, m_hs, m_err, m_ps, m_clk, mdl_start;
   int m_pos, m_n, m_pend_n;

   // Run-length monitor and scenario flags.
   logic mon_prev = 1'b0;
   int   mon_len  = 0;
   int   mon_n    = 0;
   bit   mon_ok   = 0;
   bit   saw3, saw4;
   int   err_seen;

   always @(posedge clk) begin
      if (reset) begin
         m_started = 0; m_pos = 0; m_n = RESET_DIV; m_pend = 0; m_pend_n = 0;
         m_err = 0; m_ps = 0; m_clk = 0; m_hs = 0;
         chk_en = 1; rst_edge = 1;
      end else begin
         rst_edge  = 0;
         m_hs      = divider_valid && !m_pend;
         mdl_start = !m_started || (m_pos + 1 == m_n);
         m_err     = m_hs && (int'(divider) < 2);
         if (mdl_start) begin
            m_pos = 0;
            if (m_pend) begin
               m_n    = m_pend_n;
               m_pend = 0;
            end
         end else begin
            m_pos++;
         end
         if (m_hs) begin
            m_pend   = 1;
            m_pend_n = (int'(divider) < 2) ? 2 : int'(divider);
         end
         m_started = 1;
         m_ps      = mdl_start;
         m_clk     = (m_pos < m_n / 2);
      end
      #1;
      if (chk_en) begin
         check("clock_out",      32'(clock_out),      32'(m_clk));
         check("period_start",   32'(period_start),   32'(m_ps));
         check("active_divider", 32'(active_divider), 32'(m_n));
         check("divider_ready",  32'(divider_ready),  32'(!m_pend));
         check("divider_error",  32'(divider_error),  32'(m_err));
         if (active_divider == W'(3)) saw3 = 1;
         if (active_divider == W'(4)) saw4 = 1;
         if (divider_error === 1'b1) err_seen++;
         // High run = floor(N/2), low run = ceil(N/2) of the period it belongs to.
         if (rst_edge) begin
            mon_ok  = 0;
            mon_len = 0;
         end else begin
            if (clock_out !== mon_prev) begin
               if (mon_ok) begin
                  if (mon_prev === 1'b1) check("high_len", 32'(mon_len), 32'(mon_n / 2));
                  else                   check("low_len",  32'(mon_len), 32'(mon_n - mon_n / 2));
               end
               if (clock_out === 1'b1) mon_ok = 1;
               mon_len = 1;
            end else begin
               mon_len++;
            end
            if (period_start === 1'b1) mon_n = m_n;
         end
         mon_prev = clock_out;
      end
   end

   // Sits 2 time units after the active edge, where the model is settled.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input int n);
      bit ok;
      ok = 0;
      divider       = W'(n);
      divider_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         step();
         ok = m_hs;
      end
      divider_valid = 1'b0;
      check("request_accepted", 32'(ok), 32'(1));
   endtask

   task automatic wait_active(input int n);
      int k;
      k = 0;
      while (int'(active_divider) != n && k < 100) begin
         step();
         k++;
      end
      check("wait_active", 32'(active_divider), 32'(n));
   endtask

   initial begin
      int   cnt;
      logic [4:0] pat;
      reset = 1'b1; divider = '0; divider_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset default: divide-by-2 starting with a rising edge.
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_clock_out",    32'(clock_out),    32'(i % 2 == 0));
         check("rst_period_start", 32'(period_start), 32'(i % 2 == 0));
      end
      check("rst_active", 32'(active_divider), 32'(2));
      check("rst_ready",  32'(divider_ready),  32'(1));

      // Odd ratio: 2 high / 3 low and clock/5.
      request(5);
      wait_active(5);
      pat = '0;
      for (int i = 0; i < 5; i++) begin
         pat = {pat[3:0], clock_out};
         if (i < 4) step();
      end
      check("n5_pattern", 32'(pat), 32'(5'b11000));
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (period_start === 1'b1) cnt++;
      end
      check("n5_freq_in_tol", 32'(cnt >= 19 && cnt <= 21), 32'(1));

      // Handshake boundary: request on a period-start edge, ignored second request.
      request(8);
      wait_active(8);
      saw3 = 0; saw4 = 0;
      cnt = 0;
      while (!m_ps && cnt < 20) begin step(); cnt++; end
      repeat (7) step();
      divider = W'(4); divider_valid = 1'b1;
      step();
      check("hs_on_start_edge", 32'(period_start), 32'(1));
      check("hs_accepted",      32'(m_hs),         32'(1));
      divider = W'(3);
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 4) divider_valid = 1'b0;
         step();
         if (active_divider == W'(4)) begin
            cnt = k;
            break;
         end
      end
      divider_valid = 1'b0;
      check("old_period_latency", 32'(cnt),           32'(8));
      check("ready_on_load",      32'(divider_ready), 32'(1));
      repeat (40) step();
      check("second_req_ignored", 32'(saw3), 32'(0));

      // Invalid ratios are clamped to 2 and flagged.
      request(6);
      wait_active(6);
      err_seen = 0;
      request(0);
      wait_active(2);
      request(1);
      repeat (20) step();
      check("error_pulses", 32'(err_seen), 32'(2));
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (clock_out === 1'b1) cnt++;
      end
      check("div2_high_count", 32'(cnt), 32'(5));

      // Glitch-free switching across random ratios.
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(0, 30)) step();
         request(int'($urandom_range(2, 20)));
      end
      repeat (45) step();

      // Reset with a change pending.
      request(10);
      wait_active(10);
      saw4 = 0;
      request(4);
      check("pending_ready_low", 32'(divider_ready), 32'(0));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_clock_out", 32'(clock_out),      32'(0));
      check("mid_rst_active",    32'(active_divider), 32'(2));
      check("mid_rst_ready",     32'(divider_ready),  32'(1));
      repeat (30) step();
      check("pending_dropped", 32'(saw4), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_programmable_clock_divider
